// File: rtl/onchip_sram_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters, the arbiter and the SRAM s1 port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface onchip_sram_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;
  logic [DATA_W-1:0] ram_readdata;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
    input  ram_readdata
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
    output ram_readdata
  );
endinterface

// File: rtl/onchip_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two Avalon-MM masters,
// with 2-cycle tagged read return, reset_req gating and out-of-range blocking.
module onchip_sram_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int NUM_WORDS = 90112
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  onchip_sram_arbiter_if.slave  bus,
  output logic                  err_range
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_WORDS);

  typedef enum logic {RR_M0, RR_M1} rr_e;

  typedef struct packed {
    logic valid;
    logic owner;
    logic oor;
  } tag_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } ret_t;

  rr_e  rr_last, rr_next;
  tag_t tag1;
  ret_t tag2;

  logic              req0, req1, gnt0, gnt1, issue, in_range;
  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic [DATA_W-1:0] sel_writedata;
  logic              sel_write;
  logic [DATA_W-1:0] rd0, rd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_last <= RR_M1;
    else       rr_last <= rr_next;
  end

  always_comb begin
    req0    = bus.m0_read | bus.m0_write;
    req1    = bus.m1_read | bus.m1_write;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rr_next = rr_last;
    if (!reset_req) begin
      if (req0 && (!req1 || rr_last == RR_M1)) gnt0 = 1'b1;
      else if (req1)                           gnt1 = 1'b1;
    end
    if (gnt0)      rr_next = RR_M0;
    else if (gnt1) rr_next = RR_M1;
  end

  assign issue          = gnt0 | gnt1;
  assign sel_address    = gnt1 ? bus.m1_address    : bus.m0_address;
  assign sel_byteenable = gnt1 ? bus.m1_byteenable : bus.m0_byteenable;
  assign sel_writedata  = gnt1 ? bus.m1_writedata  : bus.m0_writedata;
  // read+write together is treated as a write
  assign sel_write      = gnt1 ? bus.m1_write      : bus.m0_write;
  assign in_range       = {1'b0, sel_address} < LIMIT;

  assign bus.m0_waitrequest = reset_req | (req0 & ~gnt0);
  assign bus.m1_waitrequest = reset_req | (req1 & ~gnt1);

  assign bus.ram_address    = sel_address;
  assign bus.ram_byteenable = sel_byteenable;
  assign bus.ram_writedata  = sel_writedata;
  assign bus.ram_chipselect = issue & in_range;
  assign bus.ram_write      = issue & in_range & sel_write;
  assign bus.ram_clken      = ~reset_req;

  // Stage 1 pairs with ram_readdata in T+1; stage 2 marks the registered return in T+2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1      <= '0;
      tag2      <= '0;
      rd0       <= '0;
      rd1       <= '0;
      err_range <= 1'b0;
    end else begin
      tag1.valid <= issue & ~sel_write;
      tag1.owner <= gnt1;
      tag1.oor   <= ~in_range;
      tag2.valid <= tag1.valid;
      tag2.owner <= tag1.owner;
      if (tag1.valid) begin
        if (tag1.owner) rd1 <= tag1.oor ? '0 : bus.ram_readdata;
        else            rd0 <= tag1.oor ? '0 : bus.ram_readdata;
      end
      if (issue && !in_range) err_range <= 1'b1;
    end
  end

  assign bus.m0_readdata      = rd0;
  assign bus.m1_readdata      = rd1;
  assign bus.m0_readdatavalid = tag2.valid & ~tag2.owner;
  assign bus.m1_readdatavalid = tag2.valid &  tag2.owner;

endmodule

// File: tb/tb_onchip_sram_arbiter.sv
// Randomized + directed bench for onchip_sram_arbiter against a per-cycle behavioural model.
module tb_onchip_sram_arbiter;
  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int NUM_WORDS = 90112;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_req = 1'b0;
  logic err_range;

  onchip_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

  onchip_sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .NUM_WORDS(NUM_WORDS)
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .bus(bus), .err_range(err_range)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] be);
    bit [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // Environment SRAM: registered q, gated by clken.
  bit [31:0] sram [NUM_WORDS];
  logic [31:0] sram_q = '0;
  assign bus.ram_readdata = sram_q;
  always @(posedge clk) begin
    if (bus.ram_clken && bus.ram_chipselect) begin
      if (bus.ram_write)
        sram[bus.ram_address] = merge(sram[bus.ram_address], bus.ram_writedata, bus.ram_byteenable);
      else
        sram_q <= sram[bus.ram_address];
    end
  end

  // Behavioural reference: one decision per cycle, returns queued with due cycle.
  typedef struct { int due; bit owner; bit [31:0] data; } ret_t;
  ret_t      rq[$];
  bit [31:0] ref_mem [NUM_WORDS];
  int        cyc = 0;
  bit        m_rr = 1'b1;
  bit        m_err = 1'b0;
  bit [31:0] m_rd0 = '0, m_rd1 = '0;

  always @(negedge clk) begin
    bit r0, r1, g0, g1, e_v0, e_v1, wr, inr, own;
    int addr;
    bit [3:0] be;
    bit [31:0] wd;
    ret_t r;
    cyc++;
    if (reset) begin
      rq.delete();
      m_rr = 1'b1; m_err = 1'b0; m_rd0 = '0; m_rd1 = '0;
      chk("rst_rdv0", bus.m0_readdatavalid, 0);
      chk("rst_rdv1", bus.m1_readdatavalid, 0);
      chk("rst_rd0", bus.m0_readdata, 0);
      chk("rst_rd1", bus.m1_readdata, 0);
      chk("rst_err", err_range, 0);
    end else begin
      e_v0 = 0; e_v1 = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.owner) begin e_v1 = 1; m_rd1 = r.data; end
        else         begin e_v0 = 1; m_rd0 = r.data; end
      end
      chk("rdv0", bus.m0_readdatavalid, e_v0);
      chk("rdv1", bus.m1_readdatavalid, e_v1);
      chk("rd0", bus.m0_readdata, m_rd0);
      chk("rd1", bus.m1_readdata, m_rd1);
      chk("err_range", err_range, m_err);

      r0 = bus.m0_read | bus.m0_write;
      r1 = bus.m1_read | bus.m1_write;
      g0 = 0; g1 = 0;
      if (!reset_req) begin
        if (r0 && r1) begin g0 = (m_rr == 1'b1); g1 = !g0; end
        else begin g0 = r0; g1 = r1; end
      end
      chk("wait0", bus.m0_waitrequest, reset_req | (r0 & !g0));
      chk("wait1", bus.m1_waitrequest, reset_req | (r1 & !g1));
      chk("clken", bus.ram_clken, !reset_req);

      if (g0 || g1) begin
        own  = g1;
        addr = own ? int'(bus.m1_address)   : int'(bus.m0_address);
        be   = own ? bus.m1_byteenable : bus.m0_byteenable;
        wd   = own ? bus.m1_writedata  : bus.m0_writedata;
        wr   = own ? bus.m1_write      : bus.m0_write;
        inr  = addr < NUM_WORDS;
        chk("ram_cs", bus.ram_chipselect, inr);
        chk("ram_write", bus.ram_write, wr & inr);
        if (inr) begin
          chk("ram_addr", bus.ram_address, addr);
          if (wr) begin
            chk("ram_be", bus.ram_byteenable, be);
            chk("ram_wd", bus.ram_writedata, wd);
          end
        end
        m_rr = own;
        if (!inr) m_err = 1'b1;
        if (wr && inr) ref_mem[addr] = merge(ref_mem[addr], wd, be);
        if (!wr) begin
          r.due = cyc + 2; r.owner = own; r.data = inr ? ref_mem[addr] : '0;
          rq.push_back(r);
        end
      end else begin
        chk("ram_cs_idle", bus.ram_chipselect, 0);
        chk("ram_write_idle", bus.ram_write, 0);
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_m0(input bit rd, input bit wr, input int addr, input bit [3:0] be, input bit [31:0] d);
    bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = ADDR_W'(addr);
    bus.m0_byteenable = be; bus.m0_writedata = d;
  endtask

  task automatic set_m1(input bit rd, input bit wr, input int addr, input bit [3:0] be, input bit [31:0] d);
    bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = ADDR_W'(addr);
    bus.m1_byteenable = be; bus.m1_writedata = d;
  endtask

  task automatic idle;
    set_m0(0, 0, 0, 4'h0, '0);
    set_m1(0, 0, 0, 4'h0, '0);
  endtask

  initial begin
    idle();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // m1 byte-lane merge: FFFFFFFF then CC on lane 0 -> FFFFFFCC
    set_m1(0, 1, 5, 4'hF, 32'hFFFF_FFFF); tick();
    set_m1(0, 1, 5, 4'h1, 32'h0000_00CC); tick();
    set_m1(1, 0, 5, 4'hF, '0); tick();
    idle(); tick();
    #1 chk("bm_rdv1", bus.m1_readdatavalid, 1);
    chk("bm_rd1", bus.m1_readdata, 32'hFFFF_FFCC);

    // contention: rr_last is m1, so m0 wins first, then alternation
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        set_m0(1, 0, 16 + k, 4'hF, '0);
        set_m1(1, 0, 32 + k, 4'hF, '0);
      end else idle();
      #1;
      if (k < 6) begin
        chk("alt_wait0", bus.m0_waitrequest, (k % 2));
        chk("alt_wait1", bus.m1_waitrequest, 1 - (k % 2));
      end
      if (k >= 2) begin
        chk("alt_rdv0", bus.m0_readdatavalid, ((k - 2) % 2) == 0);
        chk("alt_rdv1", bus.m1_readdatavalid, ((k - 2) % 2) == 1);
      end
      tick();
    end

    // write then read back, 2-cycle latency
    set_m0(0, 1, 32'h100, 4'hF, 32'hA5A5_1234); tick();
    set_m0(1, 0, 32'h100, 4'hF, '0);
    #1 chk("wr_rd_wait0", bus.m0_waitrequest, 0);
    tick();
    idle();
    #1 chk("wr_rd_rdv_t1", bus.m0_readdatavalid, 0);
    tick();
    #1 chk("wr_rd_rdv_t2", bus.m0_readdatavalid, 1);
    chk("wr_rd_data", bus.m0_readdata, 32'hA5A5_1234);

    // out-of-range read and write
    set_m0(1, 0, NUM_WORDS, 4'hF, '0);
    #1 chk("oor_cs", bus.ram_chipselect, 0);
    chk("oor_wait0", bus.m0_waitrequest, 0);
    tick();
    idle();
    #1 chk("oor_err_t1", err_range, 1);
    tick();
    #1 chk("oor_rdv", bus.m0_readdatavalid, 1);
    chk("oor_rd", bus.m0_readdata, 0);
    set_m0(0, 1, 90200, 4'hF, 32'hDEAD_BEEF);
    #1 chk("oor_wr_cs", bus.ram_chipselect, 0);
    chk("oor_wr_we", bus.ram_write, 0);
    tick();
    idle();
    #1 chk("oor_err_hold", err_range, 1);

    // reset_req gate with a read in flight
    set_m0(1, 0, 32'h100, 4'hF, '0); tick();
    reset_req = 1'b1;
    set_m0(1, 0, 32'h100, 4'hF, '0);
    set_m1(1, 0, 7, 4'hF, '0);
    #1 chk("gate_wait0", bus.m0_waitrequest, 1);
    chk("gate_wait1", bus.m1_waitrequest, 1);
    chk("gate_clken", bus.ram_clken, 0);
    chk("gate_cs", bus.ram_chipselect, 0);
    tick();
    #1 chk("gate_rdv0", bus.m0_readdatavalid, 1);
    chk("gate_rd0", bus.m0_readdata, 32'hA5A5_1234);
    repeat (4) tick();
    reset_req = 1'b0;
    set_m1(0, 0, 0, 4'h0, '0);
    #1 chk("ungate_wait0", bus.m0_waitrequest, 0);
    chk("ungate_cs", bus.ram_chipselect, 1);
    chk("ungate_clken", bus.ram_clken, 1);
    tick();
    idle(); tick(); tick();

    // reset with reads in flight
    set_m0(1, 0, 5, 4'hF, '0); tick();
    set_m1(1, 0, 5, 4'hF, '0);
    set_m0(0, 0, 0, 4'h0, '0);
    #2 reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("post_rst_rdv0", bus.m0_readdatavalid, 0);
      chk("post_rst_rdv1", bus.m1_readdatavalid, 0);
      tick();
    end
    chk("post_rst_err", err_range, 0);
    set_m0(1, 0, 1, 4'hF, '0);
    set_m1(1, 0, 2, 4'hF, '0);
    #1 chk("post_rst_win0", bus.m0_waitrequest, 0);
    chk("post_rst_lose1", bus.m1_waitrequest, 1);
    tick();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int a0, a1;
      bit [2:0] op0, op1;
      a0 = ($urandom_range(0, 15) == 0) ? (NUM_WORDS - 1 + int'($urandom_range(0, 1))) : int'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 15) == 0) ? (NUM_WORDS + int'($urandom_range(0, 50))) : int'($urandom_range(0, 31));
      op0 = 3'($urandom_range(0, 7));
      op1 = 3'($urandom_range(0, 7));
      set_m0(op0[0], op0[1] & op0[2], a0, 4'($urandom), $urandom);
      set_m1(op1[0], op1[1] & op1[2], a1, 4'($urandom), $urandom);
      reset_req = ($urandom_range(0, 7) == 0);
      tick();
    end
    reset_req = 1'b0;
    idle();
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/onchip_sram_arbiter.md
Name: onchip_sram_arbiter

Overview:
- Shares one single-port on-chip SRAM between two Avalon-MM masters: m0 (Nios II data) and m1 (DMA/bridge).
- Arbitrates round-robin, issues at most one RAM command per cycle and tags each read so its data returns to the master that issued it.
- Honours the SRAM reset_req clock-enable gating and blocks out-of-range word addresses.
- Sits directly between the interconnect masters and the SRAM s1 port.

Parameters:
- ADDR_W, 17, word-address width on all address ports.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- NUM_WORDS, 90112, number of implemented RAM words; valid addresses are 0..NUM_WORDS-1.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- reset_req  in  1  reset request; while high, no new RAM commands are issued.
- m0_address  in  ADDR_W  m0 word address.
- m0_byteenable  in  BE_W  m0 byte lanes.
- m0_read  in  1  m0 read request.
- m0_write  in  1  m0 write request.
- m0_writedata  in  DATA_W  m0 write data.
- m0_waitrequest  out  1  high = m0 command not accepted this cycle.
- m0_readdata  out  DATA_W  m0 read data.
- m0_readdatavalid  out  1  m0 read data valid.
- m1_*: same set of signals, same widths and meaning, for m1.
- ram_address  out  ADDR_W  SRAM address.
- ram_byteenable  out  BE_W  SRAM byte enables.
- ram_chipselect  out  1  SRAM chipselect.
- ram_write  out  1  SRAM write.
- ram_writedata  out  DATA_W  SRAM write data.
- ram_clken  out  1  SRAM clock enable.
- ram_readdata  in  DATA_W  SRAM q; valid the cycle after the address is clocked in.
- err_range  out  1  sticky flag: an out-of-range access occurred.

Behaviour:
- Reset values: all readdatavalid 0; readdata 0; err_range 0; rr_last = m1, so m0 wins the first contention; read tag pipeline empty. Waitrequest is combinational and reflects the current inputs.
- Request: mX_req = mX_read | mX_write. Asserting read and write together is illegal; it is treated as a write.
- Grant is combinational and happens in the same cycle:
  - Only one master requesting: that master is granted.
  - Both requesting: the master not equal to rr_last is granted.
  - rr_last updates on every issued command.
- Waitrequest: the granted master gets waitrequest=0. The other requester gets 1. A non-requesting master sees 0, per Avalon idle convention.
- Gating: when reset_req=1, no grant is made, both waitrequests are 1 and ram_clken=0. Otherwise ram_clken=1.
- Issue: ram_* is driven combinationally from the granted master. ram_chipselect=1 only for an in-range access. ram_write = granted write and in range.
- Read pipeline:
  - Issue in cycle T. The RAM registers the address at the end of T, and ram_readdata is valid in T+1.
  - The block registers that data into the owner's readdata. readdatavalid=1 in T+2, so latency is 2 cycles.
  - Fully pipelined: back-to-back reads (one per cycle, either master) each return in order, one cycle apart.
  - A 2-deep tag shift register {valid, owner, oor} tracks each read.
- Out-of-range (address >= NUM_WORDS): the command is still accepted (waitrequest=0).
  - Write: dropped; ram_chipselect and ram_write stay 0.
  - Read: completes with normal latency; readdata=0.
  - Either case sets err_range=1, which holds until reset.
- Write then read of the same address on consecutive cycles: the read returns the new data (single-port sequential behaviour).
- reset_req asserting while reads are in flight: in-flight reads still complete and return their data. Only new issue is blocked.
- reset asserting at any time: the tag pipeline is cleared immediately, so pending readdatavalid pulses are dropped.
- readdata of the master that does not own the current return holds its previous value.

Test Plan:
- m0 writes 0xA5A5_1234 to addr 0x100 with be=4'hF, then m0 reads 0x100 -> m0_readdatavalid pulses 2 cycles after the read is accepted, with data 0xA5A5_1234.
- m0 and m1 both read continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; each readdatavalid returns to the correct master in order; waitrequest=1 on the loser each cycle.
- m1 writes 0xFFFF_FFFF, then writes 0x0000_00CC with be=4'b0001 to addr 5, then reads addr 5 -> data 0xFFFF_FFCC.
- m0 reads addr 90112 -> ram_chipselect=0, readdata=0 with readdatavalid at +2, err_range=1 and staying 1; a write to 90200 does not alter RAM.
- m0 read accepted at T, reset_req=1 from T+1 for 5 cycles -> the T read still returns at T+2; during the gate both waitrequests are 1 and ram_clken=0; normal issue resumes the cycle reset_req drops.
- Reset pulsed with 2 reads in flight -> no readdatavalid pulses afterward; err_range=0; the first contention after reset is granted to m0.
